// File: rtl/pwm_multi_ramp.sv
`timescale 1ns/1ps
// NUM_CH-channel PWM with a shared period counter. Period/duty updates are
// shadowed and applied only at a period boundary; active duty may slew per period.
module pwm_multi_ramp #(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 12,
  parameter int PERIOD    = 4000,
  parameter int RAMP_STEP = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [WIDTH-1:0]        cfg_period,
  input  logic [NUM_CH*WIDTH-1:0] cfg_duty,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    period_done,
  output logic                    ramping
);

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t PERIOD_W = word_t'(PERIOD);
  localparam word_t MIN_PER  = word_t'(2);
  localparam word_t STEP_W   = word_t'(RAMP_STEP);
  localparam word_t ONE      = word_t'(1);

  word_t                    cnt_q, cnt_d;
  word_t                    per_act_q, per_act_d;
  word_t                    shadow_period_q, shadow_period_d;
  logic [NUM_CH*WIDTH-1:0]  shadow_duty_q, shadow_duty_d;
  word_t                    duty_act_q [NUM_CH];
  word_t                    duty_act_d [NUM_CH];
  word_t                    duty_tgt_q [NUM_CH];
  word_t                    duty_tgt_d [NUM_CH];
  logic                     pending_q, pending_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     ramping_q, ramping_d;
  logic [NUM_CH-1:0]        pwm_q, pwm_d;
  logic                     bnd, accept, apply;

  // Steps act toward tgt by at most STEP_W; the clamp against diff keeps
  // the unsigned add/subtract from ever wrapping.
  function automatic word_t ramp_toward(input word_t act, input word_t tgt);
    word_t diff;
    if (STEP_W == '0) return tgt;
    diff = (tgt >= act) ? (tgt - act) : (act - tgt);
    if (diff <= STEP_W) return tgt;
    return (tgt > act) ? (act + STEP_W) : (act - STEP_W);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cnt_d           = cnt_q;
    per_act_d       = per_act_q;
    shadow_period_d = shadow_period_q;
    shadow_duty_d   = shadow_duty_q;
    duty_act_d      = duty_act_q;
    duty_tgt_d      = duty_tgt_q;
    pending_d       = pending_q;
    ramping_d       = 1'b0;
    pwm_d           = '0;

    bnd    = enable && (cnt_q == (per_act_q - ONE));
    accept = cfg_valid && cfg_ready_q;
    // While disabled a pending shadow is taken on the next clock, as if at bnd.
    apply  = pending_q && (bnd || !enable);

    // accept needs pending=0 and apply needs pending=1, so they never collide.
    if (accept) begin
      shadow_period_d = cfg_period;
      shadow_duty_d   = cfg_duty;
      pending_d       = 1'b1;
    end

    if (apply) begin
      per_act_d = (shadow_period_q < MIN_PER) ? MIN_PER : shadow_period_q;
      for (int i = 0; i < NUM_CH; i++) duty_tgt_d[i] = shadow_duty_q[i*WIDTH +: WIDTH];
      pending_d = 1'b0;
    end

    if (!enable) begin
      cnt_d = '0;
      for (int i = 0; i < NUM_CH; i++) duty_act_d[i] = '0;
    end else if (bnd) begin
      cnt_d = '0;
      for (int i = 0; i < NUM_CH; i++) duty_act_d[i] = ramp_toward(duty_act_q[i], duty_tgt_d[i]);
    end else begin
      cnt_d = cnt_q + ONE;
    end

    cfg_ready_d = !pending_d;

    // pwm is registered from next-state values so it lines up with cnt_q.
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_d < duty_act_d[i]);
      if (duty_act_d[i] != duty_tgt_d[i]) ramping_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q           <= '0;
      per_act_q       <= PERIOD_W;
      shadow_period_q <= '0;
      shadow_duty_q   <= '0;
      pending_q       <= 1'b0;
      cfg_ready_q     <= 1'b1;
      ramping_q       <= 1'b0;
      pwm_q           <= '0;
      // NOTE: the duty arrays are a handful of flops, not a RAM, so they are
      // reset element by element to give a defined state after reset.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_q[i] <= '0;
        duty_tgt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      cnt_q           <= cnt_d;
      per_act_q       <= per_act_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      pending_q       <= pending_d;
      cfg_ready_q     <= cfg_ready_d;
      ramping_q       <= ramping_d;
      pwm_q           <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_q[i] <= duty_act_d[i];
        duty_tgt_q[i] <= duty_tgt_d[i];
      end
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign pwm         = pwm_q;
  assign period_done = bnd;
  assign ramping     = ramping_q;

endmodule

// File: tb/tb_pwm_multi_ramp.sv
`timescale 1ns/1ps
// Bench for pwm_multi_ramp: two instances (RAMP_STEP 0 and 2) share stimulus and
// are compared every cycle to a period-level reference model, plus directed counts.
module tb_pwm_multi_ramp;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cfg_valid;
  logic [W-1:0]  cfg_period;
  logic [2*W-1:0] cfg_duty;
  logic          rdy   [2];
  logic [1:0]    pwm_o [2];
  logic          pd    [2];
  logic          rmp   [2];

  always #5 clk = ~clk;

  pwm_multi_ramp #(.NUM_CH(2), .WIDTH(W), .PERIOD(10), .RAMP_STEP(0)) dut0 (
    .clock(clk), .reset(rst_n), .enable(en), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .pwm(pwm_o[0]),
    .period_done(pd[0]), .ramping(rmp[0]));

  pwm_multi_ramp #(.NUM_CH(2), .WIDTH(W), .PERIOD(10), .RAMP_STEP(2)) dut1 (
    .clock(clk), .reset(rst_n), .enable(en), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .pwm(pwm_o[1]),
    .period_done(pd[1]), .ramping(rmp[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one set per instance.
  int m_cnt [2];
  int m_per [2];
  int m_act [2][2];
  int m_tgt [2][2];
  int m_pend[2];
  int m_shp [2];
  int m_shd [2][2];

  int hi  [2][2];
  int pdc [2];

  int t4_up [4] = '{2, 4, 6, 7};
  int t4_dn [4] = '{5, 3, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rstep(input int m);
    return (m == 0) ? 0 : 2;
  endfunction

  function automatic int toward(input int a, input int t, input int s);
    if (s == 0) return t;
    if (a < t) return (a + s > t) ? t : a + s;
    return (a - s < t) ? t : a - s;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_per[m] = 10; m_pend[m] = 0; m_shp[m] = 0;
      for (int c = 0; c < 2; c++) begin
        m_act[m][c] = 0; m_tgt[m][c] = 0; m_shd[m][c] = 0;
      end
    end
  endtask

  // One clock edge of the model, using the inputs that were stable across it.
  task automatic model_clock();
    bit bnd, acc;
    for (int m = 0; m < 2; m++) begin
      bnd = (en === 1'b1) && (m_cnt[m] == m_per[m] - 1);
      acc = (cfg_valid === 1'b1) && (m_pend[m] == 0);
      if (m_pend[m] != 0 && (bnd || en !== 1'b1)) begin
        m_per[m]    = (m_shp[m] < 2) ? 2 : m_shp[m];
        m_tgt[m][0] = m_shd[m][0];
        m_tgt[m][1] = m_shd[m][1];
        m_pend[m]   = 0;
      end
      if (en !== 1'b1) begin
        m_cnt[m] = 0; m_act[m][0] = 0; m_act[m][1] = 0;
      end else if (bnd) begin
        m_cnt[m] = 0;
        for (int c = 0; c < 2; c++) m_act[m][c] = toward(m_act[m][c], m_tgt[m][c], rstep(m));
      end else begin
        m_cnt[m]++;
      end
      if (acc) begin
        m_shp[m]    = int'(cfg_period);
        m_shd[m][0] = int'(cfg_duty[W-1:0]);
        m_shd[m][1] = int'(cfg_duty[2*W-1:W]);
        m_pend[m]   = 1;
      end
    end
  endtask

  // Called at a negedge: compare outputs to the model, then advance one cycle.
  task automatic tick();
    logic [1:0] e_pwm;
    logic       e_pd, e_rmp;
    for (int m = 0; m < 2; m++) begin
      e_pd  = (en === 1'b1) && (m_cnt[m] == m_per[m] - 1);
      e_rmp = (m_act[m][0] != m_tgt[m][0]) || (m_act[m][1] != m_tgt[m][1]);
      for (int c = 0; c < 2; c++) e_pwm[c] = (m_cnt[m] < m_act[m][c]);
      check($sformatf("pwm%0d", m), pwm_o[m], e_pwm);
      check($sformatf("period_done%0d", m), pd[m], e_pd);
      check($sformatf("cfg_ready%0d", m), rdy[m], (m_pend[m] == 0));
      check($sformatf("ramping%0d", m), rmp[m], e_rmp);
      for (int c = 0; c < 2; c++) hi[m][c] += int'(pwm_o[m][c]);
      pdc[m] += int'(pd[m]);
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic count_period(input int n);
    for (int m = 0; m < 2; m++) begin
      pdc[m] = 0; hi[m][0] = 0; hi[m][1] = 0;
    end
    repeat (n) tick();
  endtask

  task automatic write_cfg(input int p, input int d0, input int d1);
    bit took;
    took       = 1'b0;
    cfg_period = W'(p);
    cfg_duty   = {W'(d1), W'(d0)};
    cfg_valid  = 1'b1;
    for (int k = 0; k < 300 && !took; k++) begin
      took = (m_pend[0] == 0);
      tick();
    end
    cfg_valid = 1'b0;
    check("cfg_accept", took, 1'b1);
  endtask

  task automatic wait_apply();
    for (int k = 0; k < 300 && m_pend[0] != 0; k++) tick();
    check("ready_back", rdy[0], 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_pwm%0d", m), pwm_o[m], 2'b00);
      check($sformatf("rst_pd%0d", m), pd[m], 1'b0);
      check($sformatf("rst_ready%0d", m), rdy[m], 1'b1);
      check($sformatf("rst_ramping%0d", m), rmp[m], 1'b0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    en = 1'b1;

    // T1: duty {3,7}, period 10
    write_cfg(10, 3, 7);
    wait_apply();
    repeat (2) begin
      count_period(10);
      check("t1_ch0_high", hi[0][0], 3);
      check("t1_ch1_high", hi[0][1], 7);
      check("t1_period_done", pdc[0], 1);
    end

    // T2: duty 0 and duty above period
    write_cfg(10, 0, 15);
    wait_apply();
    count_period(20);
    check("t2_ch0_high", hi[0][0], 0);
    check("t2_ch1_high", hi[0][1], 20);
    check("t2_period_done", pdc[0], 2);

    // T3: mid-period update; held cfg_valid during the pending window is refused
    for (int m = 0; m < 2; m++) begin
      pdc[m] = 0; hi[m][0] = 0; hi[m][1] = 0;
    end
    repeat (4) tick();
    write_cfg(6, 2, 2);
    cfg_period = W'(6);
    cfg_duty   = {W'(5), W'(5)};
    cfg_valid  = 1'b1;
    repeat (3) begin
      check("t3_ready_low", rdy[0], 1'b0);
      tick();
    end
    cfg_valid = 1'b0;
    wait_apply();
    check("t3_old_period_done", pdc[0], 1);
    check("t3_old_ch1_high", hi[0][1], 10);
    count_period(12);
    check("t3_ch0_high", hi[0][0], 4);
    check("t3_ch1_high", hi[0][1], 4);
    check("t3_period_done", pdc[0], 2);

    // T4: ramp 0->7 and back on the RAMP_STEP=2 instance
    do_reset();
    write_cfg(10, 7, 0);
    wait_apply();
    for (int k = 0; k < 4; k++) begin
      check("t4_up_ramping", rmp[1], (k < 3));
      count_period(10);
      check("t4_up_duty", hi[1][0], t4_up[k]);
      check("t4_jump_duty", hi[0][0], 7);
    end
    write_cfg(10, 0, 0);
    wait_apply();
    for (int k = 0; k < 4; k++) begin
      check("t4_dn_ramping", rmp[1], (k < 3));
      count_period(10);
      check("t4_dn_duty", hi[1][0], t4_dn[k]);
    end

    // T5: disable mid-period, reconfigure while disabled, soft restart
    write_cfg(10, 7, 7);
    wait_apply();
    count_period(10);
    repeat (3) tick();
    en = 1'b0;
    tick();
    repeat (3) begin
      check("t5_pwm0_off", pwm_o[0], 2'b00);
      check("t5_pwm1_off", pwm_o[1], 2'b00);
      tick();
    end
    write_cfg(8, 7, 7);
    wait_apply();
    en = 1'b1;
    count_period(8);
    check("t5_first_ch0", hi[0][0], 0);
    check("t5_first_ramp", hi[1][0], 0);
    check("t5_period8", pdc[0], 1);
    count_period(8);
    check("t5_ch0_high", hi[0][0], 7);
    check("t5_ramp_restart", hi[1][0], 2);

    // T6: period 1 clamps to 2; reset mid-period and mid-handshake
    write_cfg(1, 1, 1);
    wait_apply();
    count_period(4);
    check("t6_ch0_high", hi[0][0], 2);
    check("t6_period_done", pdc[0], 2);
    tick();
    do_reset();
    cfg_period = W'(20);
    cfg_duty   = {W'(9), W'(9)};
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    do_reset();
    count_period(10);
    check("t6_shadow_dropped", pdc[0], 1);
    check("t6_duty_zero", hi[0][0], 0);

    // Randomized traffic
    repeat (250) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        write_cfg(int'($urandom_range(0, 24)), int'($urandom_range(0, 30)),
                  int'($urandom_range(0, 30)));
      end else if (r == 4) begin
        en = ~en;
        tick();
      end else if (r == 5) begin
        cfg_period = W'($urandom_range(0, 24));
        cfg_duty   = {W'($urandom_range(0, 30)), W'($urandom_range(0, 30))};
        cfg_valid  = 1'b1;
        repeat ($urandom_range(1, 12)) tick();
        cfg_valid  = 1'b0;
      end else if (r == 6 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        repeat ($urandom_range(1, 25)) tick();
      end
    end
    en = 1'b1;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
